// File: rtl/hls_key_run_sequencer_pkg.sv
// Shared types and sizing for the key/run sequencer in front of a locked HLS core.
package hls_seq_pkg;

  localparam int unsigned KEY_BITS = 3071;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned RET_W    = 32;
  localparam int unsigned CNT_W    = 24;
  localparam int unsigned NWORDS   = (KEY_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {
    LOAD,
    ARMED,
    START,
    WAIT,
    HOLD
  } state_e;

  // Number of meaningful bits in the final (possibly partial) key word.
  function automatic int unsigned last_word_bits(input int unsigned key_bits,
                                                 input int unsigned word_w);
    return key_bits - (((key_bits + word_w - 1) / word_w) - 1) * word_w;
  endfunction

endpackage

// File: rtl/hls_key_run_sequencer_if.sv
// Host-side key, run-request and result handshakes of the sequencer.
interface hls_key_run_sequencer_if;
  import hls_seq_pkg::*;

  logic              key_valid;
  logic              key_ready;
  logic [WORD_W-1:0] key_data;
  logic              key_loaded;
  logic              run_valid;
  logic              run_ready;
  logic              res_valid;
  logic              res_ready;
  logic [RET_W-1:0]  res_data;
  logic [CNT_W-1:0]  res_cycles;

  modport master (
    output key_valid, key_data, run_valid, res_ready,
    input  key_ready, key_loaded, run_ready, res_valid, res_data, res_cycles
  );

  modport slave (
    input  key_valid, key_data, run_valid, res_ready,
    output key_ready, key_loaded, run_ready, res_valid, res_data, res_cycles
  );

endinterface

// File: rtl/hls_key_run_sequencer_key_word_reg.sv
// Word-addressed working-key register; the last word keeps only its low valid bits.
module key_word_reg
  import hls_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [WORD_W-1:0]   wdata,
  output logic [KEY_BITS-1:0] key
);

  localparam int unsigned LAST_BITS = last_word_bits(KEY_BITS, WORD_W);

  logic [KEY_BITS-1:0] key_d;

  for (genvar g = 0; g < NWORDS; g++) begin : g_word
    localparam int unsigned LO   = g * WORD_W;
    localparam int unsigned BITS = (g == NWORDS - 1) ? LAST_BITS : WORD_W;
    assign key_d[LO +: BITS] = (we && idx == IDX_W'(g)) ? wdata[BITS-1:0] : key[LO +: BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) key <= '0;
    else     key <= key_d;
  end

endmodule

// File: rtl/hls_key_run_sequencer.sv
// Loads the core's working key, gates ap_start on a complete key and captures
// ap_return plus run latency for the host.
module hls_key_run_sequencer
  import hls_seq_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  hls_key_run_sequencer_if.slave host,
  output logic [KEY_BITS-1:0]   core_key,
  output logic                  core_start,
  input  logic                  core_ready,
  input  logic                  core_done,
  input  logic                  core_idle,
  input  logic [RET_W-1:0]      core_return
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   widx_q, widx_d, key_idx;
  logic               key_we;
  logic               key_loaded_q, key_loaded_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RET_W-1:0]   res_data_q, res_data_d;
  logic [CNT_W-1:0]   res_cycles_q, res_cycles_d;
  logic               core_start_q, res_valid_q;
  logic               key_ready, run_ready, run_take;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, key-write and result-capture decode.
  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    key_idx      = widx_q;
    key_we       = 1'b0;
    key_loaded_d = key_loaded_q;
    cnt_d        = cnt_q;
    res_data_d   = res_data_q;
    res_cycles_d = res_cycles_q;
    key_ready    = 1'b0;
    run_ready    = 1'b0;
    run_take     = 1'b0;
    case (state_q)
      LOAD: begin
        key_ready = 1'b1;
        if (host.key_valid) begin
          key_we = 1'b1;
          if (widx_q == LAST_IDX) begin
            widx_d       = '0;
            key_loaded_d = 1'b1;
            state_d      = ARMED;
          end else begin
            widx_d = widx_q + IDX_W'(1);
          end
        end
      end
      ARMED: begin
        run_ready = core_idle;
        run_take  = host.run_valid && core_idle;
        key_ready = !run_take;
        if (run_take) begin
          cnt_d   = '0;
          state_d = START;
        end else if (host.key_valid) begin
          // Any new word invalidates the key until a full reload completes.
          key_we       = 1'b1;
          key_idx      = '0;
          widx_d       = IDX_W'(1);
          key_loaded_d = 1'b0;
          state_d      = LOAD;
        end
      end
      START: begin
        cnt_d = cnt_inc;
        if (core_ready) begin
          if (core_done) begin
            res_data_d   = core_return;
            res_cycles_d = cnt_q;
            state_d      = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (core_done) begin
          res_data_d   = core_return;
          res_cycles_d = cnt_q;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (host.res_ready) state_d = ARMED;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= LOAD;
      widx_q       <= '0;
      key_loaded_q <= 1'b0;
      cnt_q        <= '0;
      res_data_q   <= '0;
      res_cycles_q <= '0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      key_loaded_q <= key_loaded_d;
      cnt_q        <= cnt_d;
      res_data_q   <= res_data_d;
      res_cycles_q <= res_cycles_d;
      core_start_q <= (state_d == START);
      res_valid_q  <= (state_d == HOLD);
    end
  end

  key_word_reg u_key (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .we    (key_we),
    .idx   (key_idx),
    .wdata (host.key_data),
    .key   (core_key)
  );

  assign core_start      = core_start_q;
  assign host.key_ready  = key_ready;
  assign host.run_ready  = run_ready;
  assign host.key_loaded = key_loaded_q;
  assign host.res_valid  = res_valid_q;
  assign host.res_data   = res_data_q;
  assign host.res_cycles = res_cycles_q;

endmodule
